// File: rtl/goldschmidt_ctrl_pkg.sv
// Shared types and encodings for the Goldschmidt divider control/datapath pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gs_div_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_N = 3'd1,
    INIT_D = 3'd2,
    ITER_N = 3'd3,
    ITER_D = 3'd4,
    FINAL  = 3'd5,
    DONE   = 3'd6
  } gs_state_t;

  // Multiplicand select
  localparam logic [1:0] ND_SEL_D    = 2'b00;
  localparam logic [1:0] ND_SEL_N    = 2'b01;
  localparam logic [1:0] ND_SEL_DREG = 2'b10;
  localparam logic [1:0] ND_SEL_NREG = 2'b11;

  // Multiplier factor select
  localparam logic K_SEL_IA          = 1'b1;
  localparam logic K_SEL_TWO_MINUS_D = 1'b0;

  typedef struct packed {
    logic       busy;
    logic       k_sel;
    logic [1:0] nd_sel;
    logic       n_en;
    logic       d_en;
  } gs_ctrl_t;

  // Per-state control word; the FINAL step writes N*(2-D) into the D register,
  // which is where the datapath takes its rounded quotient from.
  function automatic gs_ctrl_t gs_decode(input gs_state_t s);
    gs_ctrl_t c;
    c = '{busy: 1'b0, k_sel: K_SEL_TWO_MINUS_D, nd_sel: ND_SEL_D, n_en: 1'b0, d_en: 1'b0};
    case (s)
      INIT_N: c = '{busy: 1'b1, k_sel: K_SEL_IA,          nd_sel: ND_SEL_N,    n_en: 1'b1, d_en: 1'b0};
      INIT_D: c = '{busy: 1'b1, k_sel: K_SEL_IA,          nd_sel: ND_SEL_D,    n_en: 1'b0, d_en: 1'b1};
      ITER_N: c = '{busy: 1'b1, k_sel: K_SEL_TWO_MINUS_D, nd_sel: ND_SEL_NREG, n_en: 1'b1, d_en: 1'b0};
      ITER_D: c = '{busy: 1'b1, k_sel: K_SEL_TWO_MINUS_D, nd_sel: ND_SEL_DREG, n_en: 1'b0, d_en: 1'b1};
      FINAL:  c = '{busy: 1'b1, k_sel: K_SEL_TWO_MINUS_D, nd_sel: ND_SEL_NREG, n_en: 1'b0, d_en: 1'b1};
      default: c = '{busy: 1'b0, k_sel: K_SEL_TWO_MINUS_D, nd_sel: ND_SEL_D, n_en: 1'b0, d_en: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/goldschmidt_ctrl_if.sv
// Start/busy/done handshake plus datapath control strobes of the Goldschmidt sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the sequencer is idle.
interface goldschmidt_ctrl_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       result_valid;
  logic       kSelect;
  logic       nEnable;
  logic       dEnable;
  logic [1:0] ndSelect;

  // Requester / datapath side
  modport master (
    output start,
    input  busy, done, result_valid, kSelect, nEnable, dEnable, ndSelect
  );

  // Sequencer side
  modport slave (
    input  start,
    output busy, done, result_valid, kSelect, nEnable, dEnable, ndSelect
  );
endinterface

// File: rtl/goldschmidt_ctrl.sv
// Moore FSM sequencing the shared multiplier through N/D Goldschmidt updates.
// Latency: start at t -> done at t+2*ITERS (t+4 when ITERS=1); all outputs registered.
// Backpressure: start is ignored unless IDLE; nothing is queued.
module goldschmidt_ctrl
  import gs_div_pkg::*;
#(
  parameter int ITERS = 3,
  parameter int CNT_W = $clog2(ITERS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  goldschmidt_ctrl_if.slave    bus
);

  // Number of (ITER_N, ITER_D) pairs between the IA step and the final step.
  localparam int              ITER_PAIRS = (ITERS > 2) ? (ITERS - 2) : 0;
  localparam logic [CNT_W-1:0] PAIRS_C   = CNT_W'(ITER_PAIRS);

  gs_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  gs_ctrl_t         ctrl_q;
  gs_ctrl_t         ctrl_d;
  logic             done_q;
  logic             rv_q;

  assign cnt_inc = cnt_q + 1'b1;
  assign ctrl_d  = gs_decode(state_d);

  // Next-state: cnt_inc is the number of pairs completed once this ITER_D retires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = INIT_N;
      INIT_N:  state_d = INIT_D;
      INIT_D:  state_d = (ITERS > 2) ? ITER_N : FINAL;
      ITER_N:  state_d = ITER_D;
      ITER_D:  state_d = (cnt_inc < PAIRS_C) ? ITER_N : FINAL;
      FINAL:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      done_q  <= (state_d == DONE);
      if (state_q == IDLE && bus.start) begin
        cnt_q <= '0;
      end else if (state_q == ITER_D) begin
        cnt_q <= cnt_inc;
      end
      if (state_d == DONE) begin
        rv_q <= 1'b1;
      end else if (state_q == IDLE && bus.start) begin
        rv_q <= 1'b0;
      end
    end
  end

  assign bus.busy         = ctrl_q.busy;
  assign bus.done         = done_q;
  assign bus.result_valid = rv_q;
  assign bus.kSelect      = ctrl_q.k_sel;
  assign bus.ndSelect     = ctrl_q.nd_sel;
  assign bus.nEnable      = ctrl_q.n_en;
  assign bus.dEnable      = ctrl_q.d_en;

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Bench for the Goldschmidt sequencer at ITERS = 1, 3 and 5 side by side.
// Latency: n/a.
// Backpressure: n/a.
module tb_goldschmidt_ctrl;

  typedef enum int {T_IDLE, T_INIT_N, T_INIT_D, T_ITER_N, T_ITER_D, T_FINAL, T_DONE} tst_t;

  localparam int NDUT = 3;
  int iters_of [NDUT] = '{1, 3, 5};

  logic clk;
  logic reset;
  logic start_v [NDUT];
  logic [7:0] obs [NDUT];   // {busy, done, result_valid, kSelect, ndSelect[1:0], nEnable, dEnable}

  int checks;
  int failures;
  int cyc;

  goldschmidt_ctrl_if gif0 ();
  goldschmidt_ctrl_if gif1 ();
  goldschmidt_ctrl_if gif2 ();

  goldschmidt_ctrl #(.ITERS(1)) dut0 (.clk(clk), .reset(reset), .bus(gif0));
  goldschmidt_ctrl #(.ITERS(3)) dut1 (.clk(clk), .reset(reset), .bus(gif1));
  goldschmidt_ctrl #(.ITERS(5)) dut2 (.clk(clk), .reset(reset), .bus(gif2));

  assign gif0.start = start_v[0];
  assign gif1.start = start_v[1];
  assign gif2.start = start_v[2];
  assign obs[0] = {gif0.busy, gif0.done, gif0.result_valid, gif0.kSelect, gif0.ndSelect, gif0.nEnable, gif0.dEnable};
  assign obs[1] = {gif1.busy, gif1.done, gif1.result_valid, gif1.kSelect, gif1.ndSelect, gif1.nEnable, gif1.dEnable};
  assign obs[2] = {gif2.busy, gif2.done, gif2.result_valid, gif2.kSelect, gif2.ndSelect, gif2.nEnable, gif2.dEnable};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a planned list of phases per accepted run.
  tst_t cur [NDUT];
  tst_t plan [NDUT][$];
  logic rv_m [NDUT];
  int   acc [NDUT];
  int   itd [NDUT];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Outputs each phase should show, straight from the state table.
  function automatic logic [7:0] expect_vec(input tst_t s, input logic rv);
    logic b, d, k, ne, de;
    logic [1:0] nd;
    b = 1'b0; d = 1'b0; k = 1'b0; ne = 1'b0; de = 1'b0; nd = 2'b00;
    case (s)
      T_INIT_N: begin b = 1; k = 1; nd = 2'b01; ne = 1; end
      T_INIT_D: begin b = 1; k = 1; nd = 2'b00; de = 1; end
      T_ITER_N: begin b = 1; k = 0; nd = 2'b11; ne = 1; end
      T_ITER_D: begin b = 1; k = 0; nd = 2'b10; de = 1; end
      T_FINAL:  begin b = 1; k = 0; nd = 2'b11; de = 1; end
      T_DONE:   begin d = 1; end
      default:  ;
    endcase
    return {b, d, rv, k, nd, ne, de};
  endfunction

  function automatic int pairs_of(input int it);
    return (it > 2) ? it - 2 : 0;
  endfunction

  task automatic model_edge(input int d, input logic rst, input logic st);
    if (rst) begin
      plan[d].delete();
      cur[d]  = T_IDLE;
      rv_m[d] = 1'b0;
      itd[d]  = 0;
    end else if (plan[d].size() > 0) begin
      cur[d] = plan[d].pop_front();
      if (cur[d] == T_DONE) rv_m[d] = 1'b1;
    end else if (cur[d] == T_IDLE && st) begin
      cur[d]  = T_INIT_N;
      rv_m[d] = 1'b0;
      acc[d]  = cyc;
      itd[d]  = 0;
      plan[d].push_back(T_INIT_D);
      for (int p = 0; p < pairs_of(iters_of[d]); p++) begin
        plan[d].push_back(T_ITER_N);
        plan[d].push_back(T_ITER_D);
      end
      plan[d].push_back(T_FINAL);
      plan[d].push_back(T_DONE);
    end else begin
      cur[d] = T_IDLE;
    end
  endtask

  // One clock: check at the falling edge, drive inputs, advance the model on the rising edge.
  task automatic step(input logic rst, input logic [2:0] st);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("out_iters%0d", iters_of[d]), 32'(obs[d]), 32'(expect_vec(cur[d], rv_m[d])));
      chk($sformatf("n_d_excl_iters%0d", iters_of[d]), 32'(obs[d][1] & obs[d][0]), 32'd0);
      if (obs[d][4] == 1'b0 && obs[d][3:2] == 2'b10 && obs[d][0]) itd[d]++;
      if (obs[d][6]) begin
        chk($sformatf("latency_iters%0d", iters_of[d]), 32'(cyc - acc[d]),
            32'((iters_of[d] == 1) ? 4 : 2 * iters_of[d]));
        chk($sformatf("iterd_count_iters%0d", iters_of[d]), 32'(itd[d]), 32'(pairs_of(iters_of[d])));
      end
    end
    reset = rst;
    for (int d = 0; d < NDUT; d++) start_v[d] = st[d];
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) model_edge(d, rst, st[d]);
    cyc++;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    reset = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      start_v[d] = 1'b0;
      cur[d] = T_IDLE;
      rv_m[d] = 1'b0;
      acc[d] = 0;
      itd[d] = 0;
    end

    // Reset, then idle with start low
    repeat (2) step(1'b1, 3'b000);
    repeat (10) step(1'b0, 3'b000);

    // Single start pulse on all three
    step(1'b0, 3'b111);
    repeat (14) step(1'b0, 3'b000);

    // start held high: only accepted from IDLE
    repeat (20) step(1'b0, 3'b111);
    repeat (5) step(1'b0, 3'b000);

    // Reset while the ITERS=3 instance sits in ITER_N, then a fresh run
    step(1'b0, 3'b111);
    repeat (2) step(1'b0, 3'b000);
    step(1'b1, 3'b000);
    step(1'b0, 3'b111);
    repeat (14) step(1'b0, 3'b000);

    // Randomized starts with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 3'($urandom));
    end
    repeat (14) step(1'b0, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
